// File: rtl/c7b_defs.sv
// rtl/c7b_defs.sv - shared ICU definitions: FSM state encoding and packet widths
package c7b_defs;

    localparam int PKT_W  = 64;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ICU_IDLE      = 2'd0,
        ICU_LOOKUP    = 2'd1,
        ICU_MISS_REQ  = 2'd2,
        ICU_MISS_WAIT = 2'd3
    } icu_state_e;

endpackage

// File: rtl/c7bicu_array.sv
// rtl/c7bicu_array.sv - direct-mapped valid/tag/data storage for the instruction cache
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset (valid bits only)
//   rd_idx_i             combinational read index
//   rd_valid_o/tag/data  contents of the addressed line
//   wr_en_i              write tag and data at wr_idx_i
//   wr_set_valid_i       with wr_en_i, also mark the line valid
//   wr_idx_i/tag/data    write port
//   inv_all_i            clear every valid bit at the next edge (wins over a write)
module c7bicu_array
    import c7b_defs::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = ADDR_W - 3 - IDX_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [PKT_W-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic             wr_set_valid_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [PKT_W-1:0] wr_data_i,
    input  logic             inv_all_i
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [PKT_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i && wr_set_valid_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/c7bicu.sv
// rtl/c7bicu.sv - instruction cache unit, responder end of the IFU fetch interface
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   ifu_icu_addr_ic1        fetch address (bits [2:0] ignored)
//   ifu_icu_req_ic1         fetch request, level
//   icu_ifu_ack_ic1         request accepted this cycle (combinational)
//   icu_ifu_data_valid_ic2  one-cycle fetch packet strobe
//   icu_ifu_data_ic2        fetch packet, zero when not valid
//   icu_inv_all             invalidate every line
//   icu_mem_req/addr        single-beat memory read request, held until mem_icu_ack
//   mem_icu_ack             memory accepted the request
//   mem_icu_data_valid/data refill beat
module c7bicu
    import c7b_defs::*;
#(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
    input  logic              ifu_icu_req_ic1,
    output logic              icu_ifu_ack_ic1,
    output logic              icu_ifu_data_valid_ic2,
    output logic [PKT_W-1:0]  icu_ifu_data_ic2,
    input  logic              icu_inv_all,
    output logic              icu_mem_req,
    output logic [ADDR_W-1:0] icu_mem_addr,
    input  logic              mem_icu_ack,
    input  logic              mem_icu_data_valid,
    input  logic [PKT_W-1:0]  mem_icu_data
);

    localparam int TAG_W = ADDR_W - 3 - IDX_W;

    icu_state_e        state_q, state_d;
    logic [ADDR_W-1:3] addr_q, addr_d;
    logic              inv_pend_q, inv_pend_d;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [PKT_W-1:0]  rd_data;
    logic              hit;
    logic              ready;
    logic              ack;
    logic              wr_en;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^ifu_icu_addr_ic1[2:0];

    assign lk_idx = addr_q[3+IDX_W-1:3];
    assign lk_tag = addr_q[ADDR_W-1:3+IDX_W];

    c7bicu_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk            (clk),
        .resetn         (resetn),
        .rd_idx_i       (lk_idx),
        .rd_valid_o     (rd_valid),
        .rd_tag_o       (rd_tag),
        .rd_data_o      (rd_data),
        .wr_en_i        (wr_en),
        // A fill that raced an invalidate is handed to the IFU but must not
        // survive in the array.
        .wr_set_valid_i (~inv_pend_q),
        .wr_idx_i       (lk_idx),
        .wr_tag_i       (lk_tag),
        .wr_data_i      (mem_icu_data),
        .inv_all_i      (icu_inv_all)
    );

    // Hit uses the array state before any same-cycle invalidate lands.
    assign hit   = (state_q == ICU_LOOKUP) && rd_valid && (rd_tag == lk_tag);
    assign ready = (state_q == ICU_IDLE) || hit;
    // Gating with resetn keeps the ack low while reset is held, even though
    // the FSM already sits in IDLE.
    assign ack   = ifu_icu_req_ic1 && ready && resetn;
    assign icu_ifu_ack_ic1 = ack;

    always_comb begin
        state_d                = state_q;
        addr_d                 = addr_q;
        inv_pend_d             = inv_pend_q;
        icu_ifu_data_valid_ic2 = 1'b0;
        icu_ifu_data_ic2       = '0;
        icu_mem_req            = 1'b0;
        icu_mem_addr           = '0;
        wr_en                  = 1'b0;

        if (ack) begin
            addr_d = ifu_icu_addr_ic1[ADDR_W-1:3];
        end

        unique case (state_q)
            ICU_IDLE: begin
                inv_pend_d = 1'b0;
                if (ack) begin
                    state_d = ICU_LOOKUP;
                end
            end
            ICU_LOOKUP: begin
                if (hit) begin
                    icu_ifu_data_valid_ic2 = 1'b1;
                    icu_ifu_data_ic2       = rd_data;
                    state_d                = ack ? ICU_LOOKUP : ICU_IDLE;
                end else begin
                    state_d = ICU_MISS_REQ;
                end
            end
            ICU_MISS_REQ: begin
                icu_mem_req  = 1'b1;
                icu_mem_addr = {addr_q, 3'b000};
                if (icu_inv_all) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_icu_ack) begin
                    state_d = ICU_MISS_WAIT;
                end
            end
            ICU_MISS_WAIT: begin
                if (icu_inv_all) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_icu_data_valid) begin
                    wr_en                  = 1'b1;
                    icu_ifu_data_valid_ic2 = 1'b1;
                    icu_ifu_data_ic2       = mem_icu_data;
                    state_d                = ICU_IDLE;
                end
            end
            default: state_d = ICU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ICU_IDLE;
            addr_q     <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inv_pend_q <= inv_pend_d;
        end
    end

endmodule

// File: tb/tb_c7bicu.sv
// tb/tb_c7bicu.sv - randomized self-checking bench for c7bicu against a line-address cache model
module tb_c7bicu;
    import c7b_defs::*;

    localparam int IDX_W = 4;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_req  = 1'b0;
    logic        inv    = 1'b0;
    logic        m_ack  = 1'b0;
    logic        m_dv   = 1'b0;
    logic [63:0] m_data = '0;
    logic        ack, dv, mreq;
    logic [63:0] dat;
    logic [31:0] maddr;

    int n_vec = 0;
    int n_bad = 0;

    // Model: line address -> data for every line the IFU should hit on.
    logic [63:0] cache [logic [28:0]];

    c7bicu #(.IDX_W(IDX_W)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .ifu_icu_addr_ic1       (f_addr),
        .ifu_icu_req_ic1        (f_req),
        .icu_ifu_ack_ic1        (ack),
        .icu_ifu_data_valid_ic2 (dv),
        .icu_ifu_data_ic2       (dat),
        .icu_inv_all            (inv),
        .icu_mem_req            (mreq),
        .icu_mem_addr           (maddr),
        .mem_icu_ack            (m_ack),
        .mem_icu_data_valid     (m_dv),
        .mem_icu_data           (m_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // A line maps to index key[IDX_W-1:0]; a new fill evicts whatever shared it.
    task automatic model_fill(input logic [28:0] k, input logic [63:0] d);
        logic [28:0] kill[$];
        foreach (cache[x]) if (x[IDX_W-1:0] == k[IDX_W-1:0]) kill.push_back(x);
        foreach (kill[i]) cache.delete(kill[i]);
        cache[k] = d;
    endtask

    task automatic pulse_inv();
        @(posedge clk); #1; inv = 1'b1;
        @(posedge clk); #1; inv = 1'b0;
        cache.delete();
    endtask

    // One isolated fetch starting from IDLE; inv_step counts cycles from the
    // first MISS_REQ cycle (-1: none), inv_lk pulses inv_all during lookup.
    task automatic fetch(input logic [31:0] a, input int ack_dly, input int beat_dly,
                         input int inv_step, input bit inv_lk, input logic [63:0] fill);
        logic [28:0] k;
        bit          hit;
        bit          inv_seen;
        int          step;
        k = a[31:3];
        @(posedge clk); #1; f_req = 1'b1; f_addr = a;
        @(negedge clk); check("ack", ack, 1);
        @(posedge clk); #1; f_req = 1'b0; f_addr = $urandom; inv = inv_lk;
        hit = cache.exists(k);
        @(negedge clk);
        check("lk_dv", dv, hit);
        check("lk_mreq", mreq, 0);
        if (hit) check("lk_data", dat, cache[k]);
        if (inv_lk) cache.delete();
        inv_seen = 0;
        step = 0;
        if (!hit) begin
            for (int i = 0; i <= ack_dly; i++) begin
                @(posedge clk); #1;
                inv    = (step == inv_step);
                m_ack  = (i == ack_dly);
                m_dv   = 1'($urandom_range(0, 1));
                m_data = {$urandom, $urandom};
                f_req  = 1'($urandom_range(0, 1));
                if (inv) begin inv_seen = 1; cache.delete(); end
                @(negedge clk);
                check("mreq", mreq, 1);
                check("maddr", maddr, {a[31:3], 3'b000});
                check("miss_dv", dv, 0);
                check("miss_ack", ack, 0);
                step++;
            end
            for (int j = 0; j <= beat_dly; j++) begin
                @(posedge clk); #1;
                m_ack  = 1'b0;
                inv    = (step == inv_step);
                m_dv   = (j == beat_dly);
                m_data = (j == beat_dly) ? fill : {$urandom, $urandom};
                f_req  = 1'($urandom_range(0, 1));
                if (inv) begin inv_seen = 1; cache.delete(); end
                @(negedge clk);
                check("wait_mreq", mreq, 0);
                check("wait_ack", ack, 0);
                check("wait_dv", dv, (j == beat_dly));
                if (j == beat_dly) check("fill_data", dat, fill);
                step++;
            end
            if (!inv_seen) model_fill(k, fill);
        end
        @(posedge clk); #1; inv = 1'b0; m_dv = 1'b0; m_ack = 1'b0; f_req = 1'b0;
        @(negedge clk);
        check("idle_dv", dv, 0);
        check("idle_mreq", mreq, 0);
    endtask

    // Back-to-back requests that must all hit: one packet per cycle.
    task automatic stream(input logic [31:0] addrs[$]);
        logic [31:0] prev;
        @(posedge clk); #1;
        for (int i = 0; i < addrs.size(); i++) begin
            f_req = 1'b1; f_addr = addrs[i];
            @(negedge clk);
            check("st_ack", ack, 1);
            if (i > 0) begin
                prev = addrs[i-1];
                check("st_dv", dv, 1);
                check("st_data", dat, cache[prev[31:3]]);
            end
            @(posedge clk); #1;
        end
        f_req = 1'b0;
        prev = addrs[addrs.size()-1];
        @(negedge clk);
        check("st_last_dv", dv, 1);
        check("st_last_data", dat, cache[prev[31:3]]);
        @(posedge clk); #1;
        @(negedge clk);
        check("st_idle_dv", dv, 0);
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        @(posedge clk); #1; f_req = 1'b1; f_addr = a;
        @(negedge clk); check("rm_ack", ack, 1);
        @(posedge clk); #1; f_req = 1'b0;
        @(negedge clk); check("rm_lk_dv", dv, 0);
        @(posedge clk); #1; m_ack = 1'b1;
        @(negedge clk); check("rm_mreq", mreq, 1);
        @(posedge clk); #1; m_ack = 1'b0;
        @(negedge clk); check("rm_wait_mreq", mreq, 0);
        @(posedge clk); #1; resetn = 1'b0; f_req = 1'b1; f_addr = a;
        #1;
        check("rm_rst_ack", ack, 0);
        check("rm_rst_dv", dv, 0);
        check("rm_rst_data", dat, 0);
        check("rm_rst_mreq", mreq, 0);
        check("rm_rst_maddr", maddr, 0);
        cache.delete();
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1; f_req = 1'b0; m_dv = 1'b1; m_data = 64'hdead_beef_0bad_f00d;
        @(negedge clk); check("rm_late_beat_dv", dv, 0);
        @(posedge clk); #1; m_dv = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [28:0] keys[$];
        logic [31:0] a;
        int          r;

        f_req = 1'b1; f_addr = 32'h1c00_0000;
        #12;
        check("reset_ack", ack, 0);
        check("reset_dv", dv, 0);
        check("reset_data", dat, 0);
        check("reset_mreq", mreq, 0);
        check("reset_maddr", maddr, 0);
        @(posedge clk); #1; resetn = 1'b1; f_req = 1'b0;

        // Cold miss, then hit on the same line.
        fetch(32'h1c00_0000, 2, 2, -1, 0, 64'h1111_2222_3333_4444);
        fetch(32'h1c00_0000, 0, 0, -1, 0, 64'h0);
        // Streaming over two filled lines.
        fetch(32'h1c00_0008, 1, 1, -1, 0, {$urandom, $urandom});
        q = '{32'h1c00_0000, 32'h1c00_0008};
        stream(q);
        // Index-0 conflict: each evicts the other.
        fetch(32'h1c00_0080, 1, 0, -1, 0, {$urandom, $urandom});
        fetch(32'h1c00_0000, 0, 1, -1, 0, 64'h5555_6666_7777_8888);
        fetch(32'h1c00_0000, 0, 0, -1, 0, 64'h0);
        fetch(32'h1c00_0080, 0, 0, -1, 0, {$urandom, $urandom});
        // Invalidate in MISS_WAIT: data delivered, line not retained.
        fetch(32'h1c00_0100, 1, 2, 3, 0, {$urandom, $urandom});
        fetch(32'h1c00_0100, 0, 0, -1, 0, {$urandom, $urandom});
        // Invalidate during a lookup hit still returns the packet.
        fetch(32'h1c00_0100, 0, 0, -1, 1, 64'h0);
        // Reset while waiting on memory.
        reset_mid_miss(32'h1c00_0040);
        fetch(32'h1c00_0040, 0, 0, -1, 0, {$urandom, $urandom});

        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 9);
            a = 32'h1c00_0000 + 32'($urandom_range(0, 31)) * 8 + 32'($urandom_range(0, 7));
            keys.delete();
            foreach (cache[x]) keys.push_back(x);
            if (r == 0) begin
                pulse_inv();
            end else if (r <= 2 && keys.size() > 0) begin
                q.delete();
                for (int i = 0; i < int'($urandom_range(2, 5)); i++)
                    q.push_back({keys[$urandom_range(0, keys.size()-1)], 3'($urandom)});
                stream(q);
            end else begin
                fetch(a, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1,
                      ($urandom_range(0, 9) == 0), {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
